// File: rtl/clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// clk_rst_sequencer
//
// Clock/reset manager running in the PLL output clock domain. It synchronises
// the raw PLL lock, requires the lock to be stable for a programmable window,
// then releases NUM_RST active-low domain resets one after another with a fixed
// stagger. Once every reset is released it reports ready and produces a
// divided clock-enable tick. If lock is lost while resets are being released
// or while running, every reset is re-asserted at once. A sticky flag and a
// saturating counter record these lock-loss events.
//
// Parameters:
//   SYNC_STAGES        flops in the pll_locked synchroniser (>= 2)
//   LOCK_STABLE_CYCLES consecutive locked cycles needed before release (>= 1)
//   NUM_RST            number of sequenced reset outputs (>= 1)
//   RST_STAGGER        cycles between successive reset releases (>= 1)
//   CE_DIV             clock-enable divide ratio (>= 1)
//   LOSS_CNT_W         width of the lock-loss counter
//
// Ports:
//   clock            in   PLL output clock, the only clock
//   reset_n          in   asynchronous active-low reset
//   pll_locked       in   raw PLL lock, asynchronous to clock
//   clear_loss       in   one-cycle synchronous clear of the loss flag/count
//   rst_out_n        out  per-domain active-low resets, bit 0 released first
//   ready            out  high when all resets are released
//   ce_tick          out  one-cycle pulse every CE_DIV cycles while ready
//   lock_loss        out  sticky lock-lost-during-release/run flag
//   lock_loss_count  out  saturating count of lock-loss events
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module clk_rst_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_RST            = 3,
  parameter int RST_STAGGER        = 16,
  parameter int CE_DIV             = 48,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  clear_loss,
  output logic [NUM_RST-1:0]    rst_out_n,
  output logic                  ready,
  output logic                  ce_tick,
  output logic                  lock_loss,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  // Counter widths, each at least one bit so degenerate parameter values
  // still elaborate.
  localparam int STAB_W   = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int REL_LAST = (NUM_RST - 1) * RST_STAGGER;
  localparam int REL_W    = (REL_LAST > 0) ? $clog2(REL_LAST + 1) : 1;
  localparam int DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_LAST_V = REL_W'(REL_LAST);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    locked_s;
  logic [STAB_W-1:0]       stab_cnt, stab_next;
  logic [REL_W-1:0]        rel_cnt, rel_next, rel_inc;
  logic [DIV_W-1:0]        div_cnt, div_next;
  logic [NUM_RST-1:0]      rst_next;
  logic                    ready_next;
  logic                    ce_next;
  logic                    loss_event;
  logic                    loss_next;
  logic [LOSS_CNT_W-1:0]   count_next;

  // Multi-flop synchroniser for the asynchronous PLL lock. Only the last
  // stage is ever used by the sequencing logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // rel_cnt holds the number of edges since entry into RELEASE, so rel_inc is
  // the value it will have after the coming edge.
  assign rel_inc = rel_cnt + 1'b1;

  // State register plus all registered outputs and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_LOCK;
      stab_cnt        <= '0;
      rel_cnt         <= '0;
      div_cnt         <= '0;
      rst_out_n       <= '0;
      ready           <= 1'b0;
      ce_tick         <= 1'b0;
      lock_loss       <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_next;
      stab_cnt        <= stab_next;
      rel_cnt         <= rel_next;
      div_cnt         <= div_next;
      rst_out_n       <= rst_next;
      ready           <= ready_next;
      ce_tick         <= ce_next;
      lock_loss       <= loss_next;
      lock_loss_count <= count_next;
    end
  end

  // Next-state and next-output logic. Counters not belonging to the current
  // state fall back to zero so every entry into a state starts clean.
  always_comb begin
    state_next = state;
    stab_next  = '0;
    rel_next   = '0;
    div_next   = '0;
    rst_next   = rst_out_n;
    ready_next = 1'b0;
    ce_next    = 1'b0;
    loss_event = 1'b0;

    case (state)
      WAIT_LOCK: begin
        rst_next = '0;
        if (locked_s) begin
          state_next = STABILIZE;
        end
      end

      STABILIZE: begin
        rst_next = '0;
        if (!locked_s) begin
          // Lock dropped before any reset was released: just start over.
          state_next = WAIT_LOCK;
        end else if (stab_cnt == STAB_LAST) begin
          // The entry edge into RELEASE also releases bit 0.
          state_next  = RELEASE;
          rst_next[0] = 1'b1;
        end else begin
          stab_next = stab_cnt + 1'b1;
        end
      end

      RELEASE: begin
        if (!locked_s) begin
          loss_event = 1'b1;
          state_next = WAIT_LOCK;
          rst_next   = '0;
        end else if (rel_cnt == REL_LAST_V) begin
          // Last bit went out on the previous edge; enter RUN. The divider
          // starts at 1 so the first tick lands CE_DIV-1 edges after entry;
          // with CE_DIV=1 the tick is high from the entry edge onward.
          state_next = RUN;
          ready_next = 1'b1;
          if (DIV_LAST == '0) begin
            ce_next  = 1'b1;
            div_next = '0;
          end else begin
            div_next = DIV_W'(1);
          end
        end else begin
          rel_next = rel_inc;
          for (int k = 0; k < NUM_RST; k++) begin
            if (rel_inc == REL_W'(k * RST_STAGGER)) begin
              rst_next[k] = 1'b1;
            end
          end
        end
      end

      RUN: begin
        if (!locked_s) begin
          loss_event = 1'b1;
          state_next = WAIT_LOCK;
          rst_next   = '0;
        end else begin
          ready_next = 1'b1;
          if (div_cnt == DIV_LAST) begin
            ce_next  = 1'b1;
            div_next = '0;
          end else begin
            div_next = div_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_next = WAIT_LOCK;
        rst_next   = '0;
      end
    endcase
  end

  // Sticky loss flag and saturating counter. A loss event on the same edge as
  // a clear wins, leaving the flag set and the count at exactly one.
  always_comb begin
    loss_next  = lock_loss | loss_event;
    count_next = lock_loss_count;
    if (clear_loss) begin
      loss_next  = loss_event;
      count_next = LOSS_CNT_W'(loss_event);
    end else if (loss_event && (lock_loss_count != '1)) begin
      count_next = lock_loss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_sequencer
//
// Directed bench for clk_rst_sequencer with a small configuration
// (LOCK_STABLE_CYCLES=8, NUM_RST=3, RST_STAGGER=4, CE_DIV=5, LOSS_CNT_W=2).
// Expected waveforms come from a hand-derived timeline: if locked_s first
// reads 1 after edge L, reset bit 0 rises at L+9, bit 1 at L+13, bit 2 at
// L+17, ready at L+18 and ce_tick after L+22, L+27, ...
// -----------------------------------------------------------------------------
module tb_clk_rst_sequencer;

  logic       clock;
  logic       reset_n;
  logic       pll_locked;
  logic       clear_loss;
  logic [2:0] rst_out_n;
  logic       ready;
  logic       ce_tick;
  logic       lock_loss;
  logic [1:0] lock_loss_count;

  int total;
  int bad;
  int edge_num;

  clk_rst_sequencer #(
    .SYNC_STAGES        (2),
    .LOCK_STABLE_CYCLES (8),
    .NUM_RST            (3),
    .RST_STAGGER        (4),
    .CE_DIV             (5),
    .LOSS_CNT_W         (2)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .clear_loss      (clear_loss),
    .rst_out_n       (rst_out_n),
    .ready           (ready),
    .ce_tick         (ce_tick),
    .lock_loss       (lock_loss),
    .lock_loss_count (lock_loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic pll, input logic clr);
    pll_locked = pll;
    clear_loss = clr;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
    edge_num++;
  endtask

  // Hold reset for a few cycles and release it on a falling edge so the next
  // rising edge is edge 1.
  task automatic applyReset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    edge_num = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] exp_rst,
                             input logic exp_ready, input logic exp_ce,
                             input logic exp_loss, input logic [1:0] exp_cnt);
    total++;
    assert (rst_out_n === exp_rst) else begin
      bad++;
      $error("[TB] FAIL %s rst_out_n edge=%0d got=%b want=%b", tag, edge_num, rst_out_n, exp_rst);
    end
    total++;
    assert (ready === exp_ready) else begin
      bad++;
      $error("[TB] FAIL %s ready edge=%0d got=%b want=%b", tag, edge_num, ready, exp_ready);
    end
    total++;
    assert (ce_tick === exp_ce) else begin
      bad++;
      $error("[TB] FAIL %s ce_tick edge=%0d got=%b want=%b", tag, edge_num, ce_tick, exp_ce);
    end
    total++;
    assert (lock_loss === exp_loss) else begin
      bad++;
      $error("[TB] FAIL %s lock_loss edge=%0d got=%b want=%b", tag, edge_num, lock_loss, exp_loss);
    end
    total++;
    assert (lock_loss_count === exp_cnt) else begin
      bad++;
      $error("[TB] FAIL %s lock_loss_count edge=%0d got=%0d want=%0d", tag, edge_num, lock_loss_count, exp_cnt);
    end
  endtask

  // Timeline check for the current edge, given the edge L after which
  // locked_s first reads 1.
  task automatic checkTimeline(input string tag, input int lk,
                               input logic exp_loss, input logic [1:0] exp_cnt);
    logic [2:0] exp_rst;
    logic       exp_ready;
    logic       exp_ce;
    exp_rst   = {edge_num >= lk + 17, edge_num >= lk + 13, edge_num >= lk + 9};
    exp_ready = (edge_num >= lk + 18);
    exp_ce    = (edge_num >= lk + 22) && (((edge_num - lk - 22) % 5) == 0);
    checkOutput(tag, exp_rst, exp_ready, exp_ce, exp_loss, exp_cnt);
  endtask

  // Lock, wait until bit 0 is released (mid-RELEASE), then drop lock. The
  // loss lands three edges after the drop; clear_loss can be placed on that
  // same edge.
  task automatic lockLoseCycle(input logic clear_on_event, input logic [1:0] exp_cnt,
                               input logic exp_loss_before, input logic [1:0] exp_cnt_before);
    applyStimulus(1'b1, 1'b0);
    repeat (12) step();
    checkOutput("loss_release", 3'b001, 1'b0, 1'b0, exp_loss_before, exp_cnt_before);
    applyStimulus(1'b0, 1'b0);
    step();
    step();
    applyStimulus(1'b0, clear_on_event);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("loss_event", 3'b000, 1'b0, 1'b0, 1'b1, exp_cnt);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    edge_num = 0;
    reset_n  = 1'b0;
    applyStimulus(1'b1, 1'b0);

    // Power-up with lock held high; outputs must be zero while in reset.
    #12;
    checkOutput("reset_state", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    applyReset();
    for (int e = 1; e <= 42; e++) begin
      step();
      checkTimeline("powerup", 2, 1'b0, 2'd0);
      if (edge_num == 40) applyStimulus(1'b0, 1'b0);
    end

    // Loss in RUN lands at edge 43; relock after edge 45 puts locked_s at 47.
    for (int e = 43; e <= 75; e++) begin
      step();
      checkTimeline("run_loss_relock", 47, 1'b1, 2'd1);
      if (edge_num == 45) applyStimulus(1'b1, 1'b0);
    end

    // Three-cycle dropout during STABILIZE; locked_s returns after edge 11.
    applyReset();
    for (int e = 1; e <= 35; e++) begin
      step();
      checkTimeline("stab_glitch", 11, 1'b0, 2'd0);
      if (edge_num == 6) applyStimulus(1'b0, 1'b0);
      if (edge_num == 9) applyStimulus(1'b1, 1'b0);
    end

    // Four losses without a clear saturate the 2-bit count at 3.
    applyStimulus(1'b0, 1'b0);
    applyReset();
    lockLoseCycle(1'b0, 2'd1, 1'b0, 2'd0);
    lockLoseCycle(1'b0, 2'd2, 1'b1, 2'd1);
    lockLoseCycle(1'b0, 2'd3, 1'b1, 2'd2);
    lockLoseCycle(1'b0, 2'd3, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0);
    checkOutput("clear_pulse", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);

    // Clear on the same edge as a loss: loss wins with count exactly 1.
    lockLoseCycle(1'b0, 2'd1, 1'b0, 2'd0);
    lockLoseCycle(1'b1, 2'd1, 1'b1, 2'd1);

    // Asynchronous reset mid-RELEASE clears everything immediately.
    applyStimulus(1'b1, 1'b0);
    repeat (16) step();
    checkOutput("pre_async_reset", 3'b011, 1'b0, 1'b0, 1'b1, 2'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    edge_num = 0;
    for (int e = 1; e <= 30; e++) begin
      step();
      checkTimeline("after_reset", 2, 1'b0, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
